register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   Small multi-port CPU register file: two combinational read ports (RS, RT)
//   and one synchronous write port (RD).
//   Sits in the datapath between instruction decode and the ALU.
//   Supplies both source operands and accepts the writeback result.
//   Default configuration: 4 registers x 16 bits, 2-bit register specifiers.
// PARAMETERS
//   DATA_WIDTH  16               width of each register and of all data ports
//   ADDR_WIDTH  2                width of RS/RT/RD register specifiers
//   NUM_REGS    2**ADDR_WIDTH    number of registers (derived, do not override)
// PORTS
//   Clock      in   1           system clock; all state changes on rising edge
//   ResetN     in   1           asynchronous, active-low reset
//   RS         in   ADDR_WIDTH  read address, port A
//   RT         in   ADDR_WIDTH  read address, port B
//   RD         in   ADDR_WIDTH  write address
//   WriteData  in   DATA_WIDTH  write data
//   ReadRS     out  DATA_WIDTH  contents of register RS
//   ReadRT     out  DATA_WIDTH  contents of register RT
//   RegWrite   in   1           write enable, sampled on rising Clock
//   Clock domain: one clock. Reset is asynchronous and active-low.
// BEHAVIOUR
//   - Reset: ResetN low clears every register to 0 immediately, independent of Clock.
//     ReadRS and ReadRT therefore read 0 while reset is asserted.
//   - Deassertion of ResetN takes effect at the next rising Clock edge.
//   - Write: on rising Clock with ResetN high and RegWrite=1, reg[RD] <= WriteData.
//     Write latency is 1 edge. RegWrite=0 leaves all registers unchanged.
//   - Read: ReadRS = reg[RS] and ReadRT = reg[RT], purely combinational (0-cycle).
//     Outputs follow address changes with no clock.
//   - RS == RT is legal; both outputs carry the same value.
//   - Read and write of the same register in one cycle: the read returns the
//     OLD value until the edge, then the new value (no bypass).
//   - Only one register is written per edge; other registers hold their values.
//   - Register indices wrap naturally within ADDR_WIDTH; there are no illegal addresses.
//   - Writes are ignored while ResetN is low. Reset asserted mid-sequence
//     discards all prior writes.
//   - X on RegWrite or RD while a write edge occurs is a verification error.
// CONFIGURATION
//   REGFILE_ZERO_REG_EN
//     defined:   register 0 is hardwired to 0. Writes to RD=0 are discarded.
//                Reads of RS/RT=0 always return 0.
//     undefined: register 0 is an ordinary read/write register (default).
// TESTING
//   1. Reset: pulse ResetN low, RS=1, RT=2 -> ReadRS=0, ReadRT=0 during and after reset.
//   2. Write R1: RD=1, WriteData=5, RegWrite=1, one edge; then RD=2, WriteData=7,
//      one edge; RegWrite=0, RS=1, RT=2 -> ReadRS=5, ReadRT=7.
//   3. Write disabled: RegWrite=0, RD=3, WriteData=16'hFFFF, edge -> reg3 still 0.
//   4. Same-cycle read/write: RS=RD=3, WriteData=16'h1234, RegWrite=1 -> ReadRS old
//      value before edge, 16'h1234 immediately after edge.
//   5. Async reset mid-run: after step 2, drop ResetN between edges -> ReadRS/ReadRT
//      go to 0 without a clock edge.
//   6. R0 write: RD=0, WriteData=9, edge, RS=0 -> ReadRS=9 (macro undefined),
//      ReadRS=0 (REGFILE_ZERO_REG_EN defined).

Source files
------------

// File: rtl/register_file.sv
// register_file
//   Multi-port CPU register file sitting between instruction decode and the
//   ALU: two combinational read ports supply the source operands and one
//   synchronous write port accepts the writeback result.
//
//   Parameters
//      DATA_WIDTH  width of each register and of all data ports (default 16)
//      ADDR_WIDTH  width of the register specifiers (default 2)
//      NUM_REGS    2**ADDR_WIDTH, derived locally and not overridable
//
//   Ports
//      Clock      in   1           system clock, rising edge active
//      ResetN     in   1           asynchronous active-low reset, clears all registers
//      RS         in   ADDR_WIDTH  read address, port A
//      RT         in   ADDR_WIDTH  read address, port B
//      RD         in   ADDR_WIDTH  write address
//      WriteData  in   DATA_WIDTH  write data
//      RegWrite   in   1           write enable, sampled on rising Clock
//      ReadRS     out  DATA_WIDTH  contents of register RS (combinational)
//      ReadRT     out  DATA_WIDTH  contents of register RT (combinational)
//
//   Build option
//      REGFILE_ZERO_REG_EN  when defined, register 0 is hardwired to zero:
//                           writes to it are dropped and reads return 0.
//                           When undefined, register 0 is an ordinary register.

module register_file #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  Clock,
   input  logic                  ResetN,
   input  logic [ADDR_WIDTH-1:0] RS,
   input  logic [ADDR_WIDTH-1:0] RT,
   input  logic [ADDR_WIDTH-1:0] RD,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic                  RegWrite,
   output logic [DATA_WIDTH-1:0] ReadRS,
   output logic [DATA_WIDTH-1:0] ReadRT
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic                  wr_en;

`ifdef REGFILE_ZERO_REG_EN
   // Register 0 never takes a write, so its flop stays at its reset value
   // and synthesis can reduce it to a constant.
   assign wr_en = RegWrite && (RD != '0);
`else
   assign wr_en = RegWrite;
`endif

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[RD] <= WriteData;
      end
   end

   // No write-to-read bypass: a same-cycle read of RD sees the old contents
   // until the edge commits the write.
`ifdef REGFILE_ZERO_REG_EN
   assign ReadRS = (RS == '0) ? '0 : regs_q[RS];
   assign ReadRT = (RT == '0) ? '0 : regs_q[RT];
`else
   assign ReadRS = regs_q[RS];
   assign ReadRT = regs_q[RT];
`endif

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Self-checking bench for register_file (default 4 x 16 configuration).
//   Directed steps cover reset, basic writes, disabled writes, same-cycle
//   read/write ordering, asynchronous reset mid-run and register 0 handling,
//   followed by a randomized phase checked against an array model.
//   Honours REGFILE_ZERO_REG_EN the same way the design does.

module tb_register_file;

   localparam int DW = 16;
   localparam int AW = 2;
   localparam int NR = 2 ** AW;

   logic          Clock;
   logic          ResetN;
   logic [AW-1:0] RS;
   logic [AW-1:0] RT;
   logic [AW-1:0] RD;
   logic [DW-1:0] WriteData;
   logic          RegWrite;
   logic [DW-1:0] ReadRS;
   logic [DW-1:0] ReadRT;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] model [NR];

   register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .Clock     (Clock),
      .ResetN    (ResetN),
      .RS        (RS),
      .RT        (RT),
      .RD        (RD),
      .WriteData (WriteData),
      .RegWrite  (RegWrite),
      .ReadRS    (ReadRS),
      .ReadRT    (ReadRT)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] idx);
`ifdef REGFILE_ZERO_REG_EN
      if (idx == 0) return '0;
`endif
      return model[idx];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NR; i++) model[i] = '0;
   endtask

   // Applied right after each rising edge, using the inputs that were stable at it.
   task automatic model_edge();
      if (ResetN === 1'b1 && RegWrite === 1'b1) begin
`ifdef REGFILE_ZERO_REG_EN
         if (RD != 0) model[RD] = WriteData;
`else
         model[RD] = WriteData;
`endif
      end
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reads(input string tag);
      check({tag, "_rs"}, ReadRS, model_read(RS));
      check({tag, "_rt"}, ReadRT, model_read(RT));
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge Clock);
      RD = a; WriteData = d; RegWrite = 1'b1;
      @(posedge Clock);
      #1 model_edge();
   endtask

   initial begin
      ResetN = 1'b0; RS = 2'd1; RT = 2'd2; RD = '0; WriteData = '0; RegWrite = 1'b0;
      model_clear();

      // Reset held across clock edges.
      repeat (2) @(posedge Clock);
      #1;
      check("reset_during_rs", ReadRS, 16'h0000);
      check("reset_during_rt", ReadRT, 16'h0000);
      @(negedge Clock);
      ResetN = 1'b1;
      @(posedge Clock);
      #1;
      check("reset_after_rs", ReadRS, 16'h0000);
      check("reset_after_rt", ReadRT, 16'h0000);

      // Basic writes.
      do_write(2'd1, 16'd5);
      do_write(2'd2, 16'd7);
      @(negedge Clock);
      RegWrite = 1'b0; RS = 2'd1; RT = 2'd2;
      #1;
      check("write_r1", ReadRS, 16'd5);
      check("write_r2", ReadRT, 16'd7);

      // Write disabled.
      RD = 2'd3; WriteData = 16'hFFFF; RegWrite = 1'b0;
      @(posedge Clock);
      #1 model_edge();
      RS = 2'd3;
      #1;
      check("wr_disabled_r3", ReadRS, 16'h0000);
      RT = 2'd1;
      #1;
      check("wr_disabled_r1", ReadRT, 16'd5);

      // Same-cycle read/write of register 3, with RS == RT.
      @(negedge Clock);
      RS = 2'd3; RT = 2'd3; RD = 2'd3; WriteData = 16'h1234; RegWrite = 1'b1;
      #1;
      check("same_cycle_old", ReadRS, 16'h0000);
      @(posedge Clock);
      #1 model_edge();
      check("same_cycle_new", ReadRS, 16'h1234);
      check("rs_eq_rt", ReadRT, 16'h1234);

      // Asynchronous reset between edges; writes held off while low.
      @(negedge Clock);
      RegWrite = 1'b0; RS = 2'd1; RT = 2'd2;
      #1;
      check("pre_reset_rs", ReadRS, 16'd5);
      #2 ResetN = 1'b0;
      #1;
      check("async_reset_rs", ReadRS, 16'h0000);
      check("async_reset_rt", ReadRT, 16'h0000);
      model_clear();
      RD = 2'd1; WriteData = 16'hAAAA; RegWrite = 1'b1;
      @(posedge Clock);
      #1 model_edge();
      check("wr_in_reset", ReadRS, 16'h0000);
      @(negedge Clock);
      RegWrite = 1'b0;
      ResetN = 1'b1;
      RS = 2'd3;
      #1;
      check("reset_cleared_r3", ReadRS, 16'h0000);

      // Register 0.
      do_write(2'd0, 16'd9);
      @(negedge Clock);
      RegWrite = 1'b0; RS = 2'd0; RT = 2'd0;
      #1;
`ifdef REGFILE_ZERO_REG_EN
      check("r0_write", ReadRS, 16'd0);
`else
      check("r0_write", ReadRS, 16'd9);
`endif
      check_reads("r0_model");

      // Randomized phase.
      for (int n = 0; n < 300; n++) begin
         @(negedge Clock);
         RS = AW'($urandom); RT = AW'($urandom); RD = AW'($urandom);
         WriteData = DW'($urandom); RegWrite = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 39) == 0) begin
            #2 ResetN = 1'b0;
            model_clear();
            #1 check_reads("rand_async_rst");
         end else if (ResetN == 1'b0) begin
            ResetN = 1'b1;
         end
         #1 check_reads("rand_pre");
         @(posedge Clock);
         #1 model_edge();
         check_reads("rand_post");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
